// File: rtl/sram_play_reader.sv
// Playback reader: fetches one 16-bit sample per request from an asynchronous SRAM.
// Optional feature: define SRAM_PLAY_LOOP_EN to wrap to address 0 at the end of the recording.
module sram_play_reader #(
    parameter int ADDR_W      = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic [3:0]        i_speedup,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic [15:0]       o_data,
    output logic              o_valid,
    output logic              o_play_complete,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n,
    input  logic [15:0]       i_sram_dq
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [15:0]       data_q, data_d;
    logic              valid_q, valid_d;
    logic              complete_q, complete_d;
    logic              busy_q, busy_d;
    logic              ctrl_n_q, ctrl_n_d;

    logic [3:0]        step;
    logic [ADDR_W:0]   next_ptr;
    logic              end_reached;

    always_comb begin
        if (i_speedup == 4'd0)
            step = 4'd1;
        else if (i_speedup > 4'd8)
            step = 4'd8;
        else
            step = i_speedup;
    end

    // One extra bit so a pointer overflow also counts as running off the end.
    assign next_ptr    = {1'b0, ptr_q} + (ADDR_W+1)'(step);
    assign end_reached = next_ptr[ADDR_W] || (next_ptr[ADDR_W-1:0] > i_end_addr);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        complete_d = complete_q;
        busy_d     = 1'b0;
        ctrl_n_d   = 1'b1;

        if (i_stop) begin
            state_d    = IDLE;
            ptr_d      = '0;
            complete_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    complete_d = 1'b0;
                    if (i_start && !complete_q) begin
                        state_d  = ACCESS;
                        cnt_d    = 4'(WAIT_CYCLES);
                        ctrl_n_d = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        data_d  = i_sram_dq;
                        valid_d = 1'b1;
                        if (end_reached) begin
                            complete_d = 1'b1;
`ifdef SRAM_PLAY_LOOP_EN
                            ptr_d   = '0;
                            state_d = IDLE;
`else
                            state_d = DONE;
`endif
                        end else begin
                            ptr_d   = next_ptr[ADDR_W-1:0];
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d    = cnt_q - 4'd1;
                        ctrl_n_d = 1'b0;
                        busy_d   = 1'b1;
                    end
                end
                DONE: begin
                    complete_d = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
            ctrl_n_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
            busy_q     <= busy_d;
            ctrl_n_q   <= ctrl_n_d;
        end
    end

    assign o_data          = data_q;
    assign o_valid         = valid_q;
    assign o_play_complete = complete_q;
    assign o_busy          = busy_q;
    assign o_sram_addr     = ptr_q;
    assign o_sram_ce_n     = ctrl_n_q;
    assign o_sram_oe_n     = ctrl_n_q;
    assign o_sram_lb_n     = ctrl_n_q;
    assign o_sram_ub_n     = ctrl_n_q;
    assign o_sram_we_n     = 1'b1;

endmodule

// File: doc/sram_play_reader.md
SRAM_PLAY_READER -- requirements
Module: sram_play_reader

Interface
REQ-001 Parameter ADDR_W, default 20: SRAM word-address width.
REQ-002 Parameter WAIT_CYCLES, default 2, range 1..15: cycles the SRAM read is held before data capture.
REQ-003 i_clk  in  1  system clock; all state updates on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  one-cycle sample fetch request from the player stage.
REQ-006 i_stop  in  1  one-cycle rewind request; returns read address to 0.
REQ-007 i_speedup  in  4  address step per fetch (player speed-up parameter).
REQ-008 i_end_addr  in  ADDR_W  last valid recorded word address.
REQ-009 o_data  out  16  last captured sample, feeds player sample input.
REQ-010 o_valid  out  1  one-cycle pulse, o_data updated this cycle.
REQ-011 o_play_complete  out  1  end of recording reached.
REQ-012 o_busy  out  1  high while a read access is in progress.
REQ-013 o_sram_addr  out  ADDR_W  SRAM address.
REQ-014 o_sram_ce_n / o_sram_oe_n / o_sram_we_n / o_sram_lb_n / o_sram_ub_n  out  1 each  active-low SRAM controls.
REQ-015 i_sram_dq  in  16  SRAM read data; this block never drives the data bus.

Function
REQ-016 States: IDLE, ACCESS, DONE; all outputs registered.
REQ-017 IDLE: ce_n/oe_n/lb_n/ub_n = 1; i_start with o_play_complete low -> ACCESS at next edge, wait counter loaded WAIT_CYCLES, o_sram_addr = read pointer.
REQ-018 ACCESS: ce_n/oe_n/lb_n/ub_n = 0, o_busy = 1; counter decrements each edge; at the edge where counter = 0, capture i_sram_dq into o_data, pulse o_valid for the following cycle, leave ACCESS.
REQ-019 Latency: i_start sampled at edge E0 -> o_valid high in cycle after edge E0+WAIT_CYCLES+1 (E3 for default).
REQ-020 o_sram_we_n constant 1.
REQ-021 i_start while busy or in DONE ignored; no queuing.
REQ-022 Step = i_speedup with 0 treated as 1 and values above 8 clamped to 8.
REQ-023 Next pointer = pointer + step, computed at ADDR_W+1 bits; carry out or result > i_end_addr means end reached.
REQ-024 End reached at capture: o_play_complete set, state DONE; otherwise pointer advances, state IDLE.
REQ-025 DONE: controls inactive, o_play_complete held high, left only by i_stop or reset.
REQ-026 i_stop in any state: next edge state IDLE, pointer 0, o_play_complete 0, o_valid 0, controls deasserted; in-flight access aborted without capture; o_data retained.
REQ-027 i_stop and i_start in same cycle: stop wins, start discarded.
REQ-028 i_end_addr = 0: one sample read from address 0, then complete.
REQ-029 i_end_addr and i_speedup sampled only at capture; changes mid-access affect the next step only.

Reset
REQ-030 On i_rst low, immediately: state IDLE, pointer 0, o_sram_addr 0, o_data 0, o_valid 0, o_play_complete 0, o_busy 0, all SRAM controls 1.
REQ-031 Reset asserted mid-access aborts the access; no capture occurs.

Configuration
REQ-032 Macro SRAM_PLAY_LOOP_EN defined: on end reached, pointer wraps to 0, o_play_complete pulses high exactly one cycle, state IDLE; DONE unreachable.
REQ-033 Macro undefined: behaviour per REQ-024/REQ-025 (complete latched, DONE held).

Verification
REQ-034 Reset, sram data 0x1234 at addr 0, i_start pulse -> ce_n/oe_n low 3 cycles, o_valid pulse at E3, o_data = 0x1234, addr then 1.
REQ-035 i_speedup = 3, end = 10, repeated starts -> captures at addresses 0,3,6,9; o_play_complete rises after capture at 9; further starts ignored.
REQ-036 i_speedup = 0 and 12 -> step 1 and 8 respectively.
REQ-037 i_stop asserted one cycle into ACCESS -> no o_valid, controls high next edge, pointer 0, o_data unchanged.
REQ-038 i_start and i_stop same cycle in IDLE at pointer 5 -> pointer 0, no access started.
REQ-039 SRAM_PLAY_LOOP_EN, end = 2, step 1 -> addresses 0,1,2,0; one-cycle complete pulse after capture at 2.
